// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Bridge between the multicycle control path and a word-wide memory bus with
// a ready handshake. It handles loads, stores and instruction fetches.
//
// A request is accepted in IDLE. One bus transaction is then run in REQ.
// DONE lasts one cycle so that the control FSM can move on before the next
// request is taken.
//
// Stores: the unit builds byte strobes and lane-replicated write data.
// Loads:  the unit extracts the addressed byte or half-word and extends it.
//
// Error reporting:
//   - Misaligned requests are rejected with a one-cycle MisalignErr pulse.
//   - A transaction that waits too long for mem_ready is aborted and sets the
//     sticky TimeoutErr flag.
//
// Parameters
//   MAX_WAIT  number of REQ cycles without mem_ready before abort (>= 1)
//   CNT_W     width of the wait counter; must be able to hold MAX_WAIT
//
// Ports
//   clk, reset      clock (rising edge) / asynchronous active-high reset
//   MemRead         load or fetch requested (level)
//   MemWrite        store requested (level), wins over MemRead
//   IsFetch         with MemRead: force a word access, ignore funct3
//   funct3          access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   Adr             byte address
//   WriteData       store data (rs2)
//   ReadData        registered, aligned and extended load/fetch data
//   Stall           combinational hold for the control FSM
//   MisalignErr     one-cycle pulse: misaligned request rejected
//   TimeoutErr      sticky: a bus transaction timed out
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata   bus request side
//   mem_ready/mem_rdata                           bus response side
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IsFetch,
  input  logic [2:0]        funct3,
  input  logic [31:0]       Adr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              MisalignErr,
  output logic              TimeoutErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [1:0]         lane_q, lane_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               timeout_q, timeout_d;

  // Request decode (evaluated on the raw inputs, used only in IDLE)
  logic               req_any;
  logic               req_we;
  logic               req_fetch;
  logic [1:0]         req_size;
  logic               req_uns;
  logic               req_aligned;
  logic [3:0]         req_wstrb;
  logic [31:0]        req_wdata;

  // Load extraction (uses the lane/size latched at transaction start)
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        rd_ext;
  logic [CNT_W-1:0]   cnt_inc;

  always_comb begin
    req_any   = MemRead | MemWrite;
    req_we    = MemWrite;
    // A fetch only applies to a pure read; a store always uses funct3.
    req_fetch = IsFetch & MemRead & ~MemWrite;

    if (req_fetch || funct3[1]) begin
      // Fetches and funct3 01x/11x are word accesses.
      req_size = SZ_W;
    end else if (funct3[0]) begin
      req_size = SZ_H;
    end else begin
      req_size = SZ_B;
    end
    req_uns = ~req_fetch & funct3[2] & ~funct3[1];

    case (req_size)
      SZ_B:    req_aligned = 1'b1;
      SZ_H:    req_aligned = ~Adr[0];
      default: req_aligned = (Adr[1:0] == 2'b00);
    endcase

    req_wstrb = 4'b0000;
    req_wdata = WriteData;
    case (req_size)
      SZ_B: begin
        req_wstrb = 4'b0001 << Adr[1:0];
        req_wdata = {4{WriteData[7:0]}};
      end
      SZ_H: begin
        req_wstrb = Adr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        req_wstrb = 4'b1111;
        req_wdata = WriteData;
      end
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      SZ_B:    rd_ext = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_H:    rd_ext = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;
    Stall       = 1'b0;
    MisalignErr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (req_aligned) begin
            Stall   = 1'b1;
            addr_d  = {Adr[31:2], 2'b00};
            we_d    = req_we;
            wstrb_d = req_we ? req_wstrb : 4'b0000;
            // Reads leave the write data register alone.
            if (req_we) begin
              wdata_d = req_wdata;
            end
            size_d  = req_size;
            uns_d   = req_uns;
            lane_d  = Adr[1:0];
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            MisalignErr = 1'b1;
          end
        end
      end

      S_REQ: begin
        Stall = 1'b1;
        cnt_d = cnt_inc;
        if (mem_ready) begin
          if (!we_q) begin
            rdata_d = rd_ext;
          end
          state_d = S_DONE;
        end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
          // Abort after MAX_WAIT REQ cycles without a response.
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wstrb_q   <= 4'b0000;
      wdata_q   <= '0;
      size_q    <= SZ_B;
      uns_q     <= 1'b0;
      lane_q    <= 2'd0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  // The bus request follows the state register directly.
  // An asynchronous reset therefore drops it without waiting for a clock edge.
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req & we_q;
  assign mem_wstrb  = mem_req ? wstrb_q : 4'b0000;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign ReadData   = rdata_q;
  assign TimeoutErr = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic        IsFetch;
  logic [2:0]  funct3;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        MisalignErr;
  logic        TimeoutErr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.MAX_WAIT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .IsFetch(IsFetch), .funct3(funct3), .Adr(Adr), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .MisalignErr(MisalignErr),
    .TimeoutErr(TimeoutErr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead = 0; MemWrite = 0; IsFetch = 0; funct3 = 3'b000;
    Adr = 0; WriteData = 0; mem_ready = 0; mem_rdata = 0;
  endtask

  // Stimulus only: runs one aligned transaction with 'waits' wait states.
  // It reports what was observed; the calling test does the comparing.
  task automatic run_txn(input logic rd, input logic wr, input logic fch,
                         input logic [2:0] f3, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int waits,
                         output int stalls, output logic req0,
                         output logic [31:0] addr_s, output logic we_s,
                         output logic [3:0] strb_s, output logic [31:0] wd_s,
                         output logic stable, output logic done_stall,
                         output logic done_req, output logic [31:0] rd_s);
    tick();
    MemRead = rd; MemWrite = wr; IsFetch = fch; funct3 = f3; Adr = adr;
    WriteData = wd; mem_rdata = rdat; mem_ready = 0;
    #1;
    stalls = int'(Stall);
    req0   = mem_req;
    stable = 1'b1;
    addr_s = 0; we_s = 0; strb_s = 0; wd_s = 0;
    for (int k = 1; k <= waits + 1; k++) begin
      tick();
      mem_ready = (k == waits + 1);
      #1;
      stalls += int'(Stall);
      if (mem_req !== 1'b1) stable = 1'b0;
      if (k == 1) begin
        addr_s = mem_addr; we_s = mem_we; strb_s = mem_wstrb; wd_s = mem_wdata;
      end else if (mem_addr !== addr_s || mem_we !== we_s ||
                   mem_wstrb !== strb_s || mem_wdata !== wd_s) begin
        stable = 1'b0;
      end
    end
    tick();
    #1;
    done_stall = Stall;
    done_req   = mem_req;
    rd_s       = ReadData;
    $display("txn rd=%0d wr=%0d fetch=%0d f3=%b adr=%h wdata=%h waits=%0d stalls=%0d addr=%h strb=%b bus_wdata=%h ReadData=%h",
             rd, wr, fch, f3, adr, wd, waits, stalls, addr_s, strb_s, wd_s, rd_s);
    clear_inputs();
    tick();
  endtask

  int          st;
  logic        r0, we_o, stb, ds, dr;
  logic [31:0] a_o, wd_o, rd_o;
  logic [3:0]  sb_o;

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    tick(); tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0 || mem_wstrb !== 4'b0000) begin n_fail++; $display("FAIL reset_we_strb: got %b/%b want 0/0000", mem_we, mem_wstrb); end
    n_checks++; if (ReadData !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", ReadData, mem_addr, mem_wdata); end
    n_checks++; if (MisalignErr !== 1'b0 || TimeoutErr !== 1'b0 || Stall !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b%b want 000", MisalignErr, TimeoutErr, Stall); end
    reset = 0;
    $display("txn reset released");
  endtask

  task automatic test_lb();
    run_txn(1, 0, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (st !== 2) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 2", st); end
    n_checks++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL lb_req_in_idle: got %b want 0", r0); end
    n_checks++; if (a_o !== 32'h0000_0100 || we_o !== 1'b0 || sb_o !== 4'b0000) begin n_fail++; $display("FAIL lb_bus: got %h/%b/%b want 00000100/0/0000", a_o, we_o, sb_o); end
    n_checks++; if (rd_o !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", rd_o); end
    n_checks++; if (ds !== 1'b0 || dr !== 1'b0) begin n_fail++; $display("FAIL lb_done: got stall=%b req=%b want 0/0", ds, dr); end
  endtask

  task automatic test_sh();
    run_txn(0, 1, 0, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h1111_1111, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (we_o !== 1'b1 || sb_o !== 4'b1100) begin n_fail++; $display("FAIL sh_we_strb: got %b/%b want 1/1100", we_o, sb_o); end
    n_checks++; if (wd_o !== 32'hBEEF_BEEF || a_o !== 32'h0000_0200) begin n_fail++; $display("FAIL sh_wdata_addr: got %h/%h want beefbeef/00000200", wd_o, a_o); end
    n_checks++; if (rd_o !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL sh_rdata_kept: got %h want ffffff80", rd_o); end
  endtask

  task automatic test_lhu_wait();
    run_txn(1, 0, 0, 3'b101, 32'h0000_0010, 32'h0, 32'hABCD_8765, 3,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (st !== 5) begin n_fail++; $display("FAIL lhu_stall_cycles: got %0d want 5", st); end
    n_checks++; if (stb !== 1'b1 || a_o !== 32'h0000_0010) begin n_fail++; $display("FAIL lhu_bus_stable: got stable=%b addr=%h want 1/00000010", stb, a_o); end
    n_checks++; if (rd_o !== 32'h0000_8765) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008765", rd_o); end
  endtask

  task automatic test_loads();
    run_txn(1, 0, 0, 3'b001, 32'h0000_0032, 32'h0, 32'h9ABC_1234, 1,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (rd_o !== 32'hFFFF_9ABC) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff9abc", rd_o); end
    run_txn(1, 0, 0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_F000, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (rd_o !== 32'h0000_00F0) begin n_fail++; $display("FAIL lbu_rdata: got %h want 000000f0", rd_o); end
    run_txn(1, 0, 1, 3'b000, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (rd_o !== 32'hDEAD_BEEF || a_o !== 32'h0000_0044) begin n_fail++; $display("FAIL fetch_word: got %h @%h want deadbeef @00000044", rd_o, a_o); end
  endtask

  task automatic test_back_to_back();
    run_txn(0, 1, 0, 3'b000, 32'h0000_000E, 32'h1234_5678, 32'h0, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (sb_o !== 4'b0100 || wd_o !== 32'h7878_7878 || a_o !== 32'h0000_000C) begin n_fail++; $display("FAIL sb_bus: got %b/%h/%h want 0100/78787878/0000000c", sb_o, wd_o, a_o); end
    // Both MemRead and MemWrite high: the store must win.
    run_txn(1, 1, 0, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h5555_5555, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (we_o !== 1'b1 || sb_o !== 4'b1111 || wd_o !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_priority: got %b/%b/%h want 1/1111/cafef00d", we_o, sb_o, wd_o); end
    n_checks++; if (rd_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_rdata_kept: got %h want deadbeef", rd_o); end
  endtask

  task automatic test_misalign();
    int req_seen;
    req_seen = 0;
    tick();
    MemRead = 1; funct3 = 3'b010; Adr = 32'h0000_0021;
    #1;
    n_checks++; if (MisalignErr !== 1'b1 || Stall !== 1'b0) begin n_fail++; $display("FAIL lw_misalign_pulse: got err=%b stall=%b want 1/0", MisalignErr, Stall); end
    req_seen += int'(mem_req);
    tick();
    clear_inputs();
    #1;
    n_checks++; if (MisalignErr !== 1'b0) begin n_fail++; $display("FAIL lw_misalign_width: got %b want 0", MisalignErr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      req_seen += int'(mem_req);
    end
    n_checks++; if (req_seen !== 0 || ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_misalign_nobus: got req_cycles=%0d rdata=%h want 0/deadbeef", req_seen, ReadData); end
    $display("txn lw misaligned adr=00000021");
    MemRead = 1; funct3 = 3'b001; Adr = 32'h0000_0011;
    #1;
    n_checks++; if (MisalignErr !== 1'b1 || Stall !== 1'b0) begin n_fail++; $display("FAIL lh_misalign_pulse: got err=%b stall=%b want 1/0", MisalignErr, Stall); end
    tick();
    clear_inputs();
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL lh_misalign_nobus: got %b want 0", mem_req); end
    $display("txn lh misaligned adr=00000011");
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    n_checks++; if (TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL timeout_pre: got %b want 0", TimeoutErr); end
    tick();
    MemRead = 1; funct3 = 3'b010; Adr = 32'h0000_0080; mem_ready = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      req_cycles += int'(mem_req);
    end
    n_checks++; if (req_cycles !== 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 16", req_cycles); end
    tick();
    n_checks++; if (mem_req !== 1'b0 || ReadData !== 32'h0 || TimeoutErr !== 1'b1) begin n_fail++; $display("FAIL timeout_abort: got req=%b rdata=%h err=%b want 0/0/1", mem_req, ReadData, TimeoutErr); end
    clear_inputs();
    tick(); tick(); tick();
    n_checks++; if (TimeoutErr !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", TimeoutErr); end
    $display("txn read timeout adr=00000080 req_cycles=%0d", req_cycles);
  endtask

  task automatic test_reset_mid();
    // Leave ReadData non-zero so the reset has something to clear.
    run_txn(1, 0, 0, 3'b010, 32'h0000_0060, 32'h0, 32'h1357_9BDF, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    tick();
    MemRead = 1; funct3 = 3'b010; Adr = 32'h0000_0300;
    tick(); tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300) begin n_fail++; $display("FAIL rstmid_pre: got req=%b addr=%h want 1/00000300", mem_req, mem_addr); end
    reset = 1;
    MemRead = 0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got req=%b stall=%b want 0/0", mem_req, Stall); end
    n_checks++; if (ReadData !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || TimeoutErr !== 1'b0) begin n_fail++; $display("FAIL rstmid_regs: got %h/%h/%h/%b want 0/0/0/0", ReadData, mem_addr, mem_wdata, TimeoutErr); end
    tick();
    reset = 0;
    $display("txn reset during REQ");
    run_txn(1, 0, 0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 0,
            st, r0, a_o, we_o, sb_o, wd_o, stb, ds, dr, rd_o);
    n_checks++; if (st !== 2 || rd_o !== 32'h0000_007F) begin n_fail++; $display("FAIL rstmid_recover: got stalls=%0d rdata=%h want 2/0000007f", st, rd_o); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_lhu_wait();
    test_loads();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
